// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin scheduler sharing one UART transmitter between
//            NUM_REQ byte producers. It accepts one byte per grant through a
//            valid/ready handshake, drives the transmitter load strobe and
//            byte, follows the transmitter busy flag until the frame ends,
//            and raises a sticky error if a load is never acknowledged.
// Ports    : i_clk, i_reset      - clock, synchronous active-high reset
//            i_req_valid/data    - per-requester byte offer (byte k at [8k+7:8k])
//            o_req_ready         - one-cycle accept pulse to the winner
//            o_tx_dr, o_tx_data  - load strobe and byte to the transmitter
//            i_tx_busy           - transmitter busy flag
//            o_grant_id          - index of the requester being served
//            o_busy              - arbiter not idle
//            o_err_timeout       - sticky "transmitter never went busy" flag
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DR_CYCLES    = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_dr,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_err_timeout
);

  localparam int c_id_w = $clog2(NUM_REQ);
  localparam int c_dr_w = $clog2(DR_CYCLES + 1);
  localparam int c_to_w = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [c_id_w-1:0] c_last_id  = c_id_w'(NUM_REQ - 1);
  localparam logic [c_id_w:0]   c_num_req  = (c_id_w + 1)'(NUM_REQ);
  localparam logic [c_dr_w-1:0] c_dr_first = c_dr_w'(1);
  localparam logic [c_dr_w-1:0] c_dr_last  = c_dr_w'(DR_CYCLES);
  localparam logic [c_to_w-1:0] c_to_first = c_to_w'(1);
  localparam logic [c_to_w-1:0] c_to_limit = c_to_w'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_id_w-1:0] r_ptr;        // first requester considered next time
  logic [c_id_w-1:0] r_grant;
  logic [7:0]        r_data;
  logic [c_dr_w-1:0] r_dr_cnt;     // 1-based position inside the load pulse
  logic [c_to_w-1:0] r_to_cnt;     // cycles elapsed since the first load cycle
  logic              r_seen_busy;  // busy already observed during the load pulse
  logic              r_err;

  logic              w_found;
  logic [c_id_w-1:0] w_winner;
  logic [c_id_w:0]   w_scan_idx;
  logic [7:0]        w_winner_data;
  logic [c_id_w-1:0] w_ptr_nxt;
  logic              w_arb;
  logic              w_timeout;

  // --------------------------------------------------------------------------
  // Round-robin search: walk upward from the pointer, wrapping at NUM_REQ.
  // The scan index carries one spare bit so ptr+i can be folded back into
  // range without relying on NUM_REQ being a power of two.
  // --------------------------------------------------------------------------
  always_comb begin : p_arb
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_idx = {1'b0, r_ptr} + (c_id_w + 1)'(i);
      if (w_scan_idx >= c_num_req) begin
        w_scan_idx = w_scan_idx - c_num_req;
      end
      if (!w_found && i_req_valid[w_scan_idx[c_id_w-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx[c_id_w-1:0];
      end
    end
  end

  assign w_winner_data = i_req_data[{w_winner, 3'b000} +: 8];
  assign w_ptr_nxt     = (w_winner == c_last_id) ? '0 : w_winner + c_id_w'(1);

  // A busy transmitter in IDLE belongs to someone else (or to a frame that
  // outlived a reset), so arbitration is held off until it goes quiet.
  assign w_arb     = (r_state == S_IDLE) && w_found && !i_tx_busy;
  assign w_timeout = (r_state == S_WAIT_BUSY) && !i_tx_busy && (r_to_cnt >= c_to_limit);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin : p_state
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_tx_dr     = 1'b0;
    o_busy      = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_arb) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        o_tx_dr = 1'b1;
        // The accept pulse is tied to the first load cycle only.
        if (r_dr_cnt == c_dr_first) begin
          o_req_ready[r_grant] = 1'b1;
        end
        if (r_dr_cnt >= c_dr_last) begin
          // A fast transmitter may already have gone busy while the strobe
          // was still high; in that case there is nothing left to wait for.
          if (r_seen_busy || i_tx_busy) begin
            w_state_nxt = S_WAIT_DONE;
          end else begin
            w_state_nxt = S_WAIT_BUSY;
          end
        end
      end

      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: latched byte/grant, pointer, counters and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin : p_datapath
    if (i_reset) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_data      <= '0;
      r_dr_cnt    <= '0;
      r_to_cnt    <= '0;
      r_seen_busy <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_arb) begin
        r_data      <= w_winner_data;
        r_grant     <= w_winner;
        r_ptr       <= w_ptr_nxt;
        // Both counters describe the first load cycle once this edge passes.
        r_dr_cnt    <= c_dr_first;
        r_to_cnt    <= c_to_first;
        r_seen_busy <= 1'b0;
      end else begin
        if ((r_state == S_LOAD) && (r_dr_cnt < c_dr_last)) begin
          r_dr_cnt <= r_dr_cnt + c_dr_w'(1);
        end
        if ((r_state != S_IDLE) && (r_to_cnt < c_to_limit)) begin
          r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
        if ((r_state == S_LOAD) && i_tx_busy) begin
          r_seen_busy <= 1'b1;
        end
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_tx_data     = r_data;
  assign o_grant_id    = r_grant;
  assign o_err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. A frame-level reference
//            model (elapsed-cycle arithmetic per frame) predicts every output
//            each cycle; a small transmitter model answers the load strobe;
//            directed scenarios pin the model with literal expectations and a
//            randomized run is scored per requester against pushed bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DR_CYCLES    = 2;
  localparam int BUSY_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_dr;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DR_CYCLES    (DR_CYCLES),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_tx_dr       (tx_dr),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .o_grant_id    (grant_id),
    .o_busy        (busy),
    .o_err_timeout (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one frame at a time, phase derived from cycles elapsed
  // since the first load cycle.
  // --------------------------------------------------------------------------
  longint     cyc = 0;
  bit         m_init = 1'b0;
  bit         m_active = 1'b0;
  longint     m_t0 = 0;
  int         m_grant = 0;
  int         m_ptr = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_gotbusy = 1'b0;
  bit         m_err = 1'b0;

  task automatic model_step();
    longint k;
    if (rst) begin
      m_init = 1'b1; m_active = 1'b0; m_ptr = 0; m_grant = 0;
      m_data = 8'h00; m_err = 1'b0; m_gotbusy = 1'b0;
    end else if (m_init) begin
      if (!m_active) begin
        if (req_valid != 4'b0 && !tx_busy) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[(m_ptr + i) % NUM_REQ]) begin
              m_grant = (m_ptr + i) % NUM_REQ;
              break;
            end
          end
          m_data    = req_data[8*m_grant +: 8];
          m_ptr     = (m_grant + 1) % NUM_REQ;
          m_active  = 1'b1;
          m_t0      = cyc + 1;
          m_gotbusy = 1'b0;
        end
      end else begin
        k = cyc - m_t0;
        if (k < DR_CYCLES) begin
          if (tx_busy) m_gotbusy = 1'b1;
        end else if (m_gotbusy) begin
          if (!tx_busy) m_active = 1'b0;
        end else if (tx_busy) begin
          m_gotbusy = 1'b1;
        end else if (k + 1 >= BUSY_TIMEOUT) begin
          m_err    = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Compare process and observation logs (sampled on the falling edge)
  // --------------------------------------------------------------------------
  logic       s_dr = 1'b0;
  logic [3:0] s_ready = 4'b0;
  logic [7:0] s_data = 8'h00;
  int         ready_count = 0;
  int         dr_count = 0;
  int         grant_log[$];
  int         data_log[$];
  int         rx_log[$];
  longint     ready_cyc_log[$];
  longint     err_cyc = -1;
  logic       err_prev = 1'b0;
  logic [7:0] sent[4][$];
  logic [7:0] pushed[4][$];
  logic [3:0] e_ready;
  logic       e_dr;

  always @(negedge clk) begin
    s_dr    = tx_dr;
    s_ready = req_ready;
    s_data  = tx_data;
    if (m_init) begin
      if (req_ready != 4'b0) begin
        ready_count++;
        grant_log.push_back(int'(grant_id));
        data_log.push_back(int'(tx_data));
        ready_cyc_log.push_back(cyc);
        sent[grant_id].push_back(tx_data);
      end
      if (tx_dr) dr_count++;
      if (err && !err_prev) err_cyc = cyc;
      err_prev = err;

      e_ready = (m_active && cyc == m_t0) ? 4'(1 << m_grant) : 4'b0;
      e_dr    = m_active && ((cyc - m_t0) < DR_CYCLES);
      check("ready",   64'(req_ready), 64'(e_ready));
      check("tx_dr",   64'(tx_dr),     64'(e_dr));
      check("tx_data", 64'(tx_data),   64'(m_data));
      check("grant",   64'(grant_id),  64'(m_grant));
      check("busy",    64'(busy),      64'(m_active));
      check("err",     64'(err),       64'(m_err));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: transmitter model and producers, all driven from one process
  // --------------------------------------------------------------------------
  int         u_mode = 0;        // 0 normal, 1 never busy, 2 foreign busy
  bit         u_pending = 1'b0;
  int         u_lat = 0;
  int         u_len = 0;
  int         u_lat_max = 3;
  int         u_len_min = 3;
  int         u_len_max = 8;
  logic       s_dr_prev = 1'b0;
  int         p_present = 100;
  logic [7:0] pq[4][$];

  task automatic push(input int k, input logic [7:0] b);
    pq[k].push_back(b);
    pushed[k].push_back(b);
  endtask

  task automatic tick(input bit do_reset = 1'b0);
    @(posedge clk);
    #1;
    rst = do_reset;
    if (u_len > 0) u_len--;
    if (u_mode == 0 && s_dr && !s_dr_prev) begin
      rx_log.push_back(int'(s_data));
      u_pending = 1'b1;
      u_lat     = $urandom_range(0, u_lat_max);
    end
    s_dr_prev = s_dr;
    if (u_pending) begin
      if (u_lat == 0) begin
        u_pending = 1'b0;
        u_len     = $urandom_range(u_len_min, u_len_max);
      end else begin
        u_lat--;
      end
    end
    tx_busy = (u_mode == 2) ? 1'b1 : (u_mode == 1) ? 1'b0 : (u_len > 0);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (s_ready[k]) req_valid[k] = 1'b0;
      if (!req_valid[k] && pq[k].size() > 0 && $urandom_range(0, 99) < p_present) begin
        req_data[8*k +: 8] = pq[k].pop_front();
        req_valid[k]       = 1'b1;
      end
    end
  endtask

  function automatic bit quiet();
    return !busy && req_valid == 4'b0 && pq[0].size() == 0 && pq[1].size() == 0 &&
           pq[2].size() == 0 && pq[3].size() == 0 && u_len == 0 && !u_pending;
  endfunction

  task automatic run_until_quiet(input int budget, input string name);
    int n = 0;
    bit q;
    do begin
      tick();
      @(negedge clk);
      #1;
      q = quiet();
      n++;
    end while (!q && n < budget);
    check({name, "_drain"}, 64'(q), 64'd1);
  endtask

  task automatic clear_logs();
    ready_count = 0;
    dr_count    = 0;
    grant_log.delete();
    data_log.delete();
    rx_log.delete();
    ready_cyc_log.delete();
    err_cyc = -1;
  endtask

  function automatic logic [63:0] pack(input int q[$]);
    logic [63:0] w = '0;
    foreach (q[i]) w = (w << 8) | 64'(q[i] & 8'hff);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at t=%0t", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst = 1'b1; req_valid = 4'b0; req_data = 32'h0; tx_busy = 1'b0;

    // Reset state
    tick(1'b1);
    tick(1'b0);
    @(negedge clk); #1;
    check("reset_outputs", 64'({req_ready, tx_dr, tx_data, grant_id, busy, err}), 64'd0);

    // Single request
    clear_logs();
    push(0, 8'h53);
    run_until_quiet(100, "t1");
    check("t1_ready_pulses", 64'(ready_count), 64'd1);
    check("t1_dr_cycles",    64'(dr_count),    64'd2);
    check("t1_grant",        pack(grant_log),   64'h00);
    check("t1_data",         pack(data_log),    64'h53);
    check("t1_rx",           pack(rx_log),      64'h53);

    // Contention from pointer 0
    tick(1'b1);
    clear_logs();
    push(0, 8'h61); push(1, 8'h4a); push(2, 8'h01); push(3, 8'h2d);
    run_until_quiet(300, "t2");
    check("t2_ready_pulses", 64'(ready_count), 64'd4);
    check("t2_grants",       pack(grant_log),   64'h00010203);
    check("t2_data",         pack(data_log),    64'h614a012d);
    check("t2_rx",           pack(rx_log),      64'h614a012d);

    // Fairness and wrap: move pointer to 3, then req1+req3, then all four
    clear_logs();
    push(2, 8'h10);
    run_until_quiet(100, "t3a");
    push(1, 8'h11); push(3, 8'h13);
    run_until_quiet(200, "t3b");
    push(0, 8'h20); push(1, 8'h21); push(2, 8'h22); push(3, 8'h23);
    run_until_quiet(300, "t3c");
    check("t3_grants", pack(grant_log), 64'h02030102030001);
    check("t3_data",   pack(data_log),  64'h10131122232021);

    // Timeout with a transmitter that never goes busy
    clear_logs();
    u_mode = 1;
    push(2, 8'h77);
    repeat (30) tick();
    @(negedge clk); #1;
    check("t4_err_delay",    64'(err_cyc - ready_cyc_log[0]), 64'd16);
    check("t4_err_set",      64'(err),         64'd1);
    check("t4_idle",         64'(busy),        64'd0);
    check("t4_ready_pulses", 64'(ready_count), 64'd1);
    u_mode = 0;
    push(0, 8'h42);
    run_until_quiet(100, "t4b");
    check("t4_err_sticky", 64'(err), 64'd1);
    tick(1'b1);
    tick(1'b0);
    @(negedge clk); #1;
    check("t4_err_cleared", 64'(err), 64'd0);

    // Foreign busy while idle
    clear_logs();
    u_mode = 2;
    push(1, 8'h5a);
    repeat (12) tick();
    @(negedge clk); #1;
    check("t5_no_ready", 64'(ready_count), 64'd0);
    check("t5_no_dr",    64'(dr_count),    64'd0);
    u_mode = 0;
    run_until_quiet(100, "t5");
    check("t5_grant",    pack(grant_log), 64'h01);
    check("t5_data",     pack(data_log),  64'h5a);
    check("t5_dr",       64'(dr_count),   64'd2);

    // Reset during WAIT_DONE
    u_lat_max = 0; u_len_min = 10; u_len_max = 10;
    push(0, 8'h11);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      tick();
      @(negedge clk); #1;
      hit = busy && tx_busy && !tx_dr && req_ready == 4'b0;
    end
    check("t6_reached_wait_done", 64'(hit), 64'd1);
    tick(1'b1);
    tick(1'b0);
    @(negedge clk); #1;
    check("t6_reset_outputs", 64'({req_ready, tx_dr, tx_data, grant_id, busy, err}), 64'd0);
    u_lat_max = 3; u_len_min = 3; u_len_max = 8;
    clear_logs();
    push(0, 8'h2d); push(1, 8'h3c);
    run_until_quiet(200, "t6");
    check("t6_grants", pack(grant_log), 64'h0001);
    check("t6_data",   pack(data_log),  64'h2d3c);
    check("t6_rx",     pack(rx_log),    64'h2d3c);

    // Randomized traffic
    u_lat_max = 5;
    p_present = 60;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) push($urandom_range(0, 3), 8'($urandom));
      tick();
    end
    run_until_quiet(3000, "rand");

    // Every pushed byte accepted exactly once, in order, per requester
    for (int k = 0; k < NUM_REQ; k++) begin
      check($sformatf("sb_count_%0d", k), 64'(sent[k].size()), 64'(pushed[k].size()));
      for (int i = 0; i < pushed[k].size() && i < sent[k].size(); i++) begin
        check($sformatf("sb_byte_%0d_%0d", k, i), 64'(sent[k][i]), 64'(pushed[k][i]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
